// File: rtl/pc_fetch.sv
// PC register and instruction-fetch stage: req/ack fetch into a single-entry decode buffer.
// Optional PC_ALIGN_CHECK_EN: keep misaligned redirect targets and flag them on pc_misalign.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    input  logic        id_ready,
    output logic        pc_misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_addr;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc_plus4;
    logic        r_id_valid;
    logic        w_id_valid_next;
    logic        w_capture;
    logic        w_redirect_taken;
    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_redirect_taken = redirect && (r_state != IDLE);

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_redir_pc = next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect_taken && (next_pc[1:0] != 2'b00);
        end
    end

    assign pc_misalign = r_misalign;
`else
    assign w_redir_pc  = next_pc & 32'hFFFF_FFFC;
    assign pc_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_id_valid_next = r_id_valid;
        w_capture       = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    w_pc_next    = w_redir_pc;
                    w_state_next = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    w_capture       = 1'b1;
                    w_id_valid_next = 1'b1;
                    w_pc_next       = w_pc_plus4;
                    w_state_next    = HOLD;
                end
            end
            DROP: begin
                if (redirect) begin
                    w_pc_next = w_redir_pc;
                end
                if (imem_ack) begin
                    w_state_next = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_id_valid_next = 1'b0;
                    w_pc_next       = w_redir_pc;
                    w_state_next    = FETCH;
                end else if (id_ready) begin
                    w_id_valid_next = 1'b0;
                    w_state_next    = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Fetch address follows the PC being loaded whenever FETCH is (re)entered; held in DROP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_pc_plus4 <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_id_valid <= w_id_valid_next;
            if (w_state_next == FETCH) begin
                r_addr <= w_pc_next;
            end
            if (w_capture) begin
                r_id_instr    <= imem_rdata;
                r_id_pc_plus4 <= r_addr + 32'd4;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign imem_req    = (r_state == FETCH) || (r_state == DROP);
    assign imem_addr   = r_addr;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc_plus4 = r_id_pc_plus4;

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch stage of the MIPS pipeline. Holds the current PC and issues word fetches to instruction memory over a req/ack handshake. Each returned instruction goes into a single-entry buffer for decode. On a redirect it loads the next-PC mux output, drops any stale fetch, and feeds `pc_plus4` back to mux input `a`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `next_pc`  in  32: next-PC mux output `pc_mux`.
- `redirect`  in  1: mux select is non-sequential (`choose != 2'b00`); load `next_pc`.
- `pc`  out  32: current PC.
- `pc_plus4`  out  32: combinational `pc + 4`, drives mux input `a`.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address, latched at issue.
- `imem_ack`  in  1: memory response valid; ignored when `imem_req` = 0.
- `imem_rdata`  in  32: instruction word, valid with `imem_ack`.
- `id_valid`  out  1: buffer holds an instruction for decode.
- `id_instr`  out  32: buffered instruction.
- `id_pc_plus4`  out  32: PC+4 of the buffered instruction.
- `id_ready`  in  1: decode accepts the buffer this cycle.
- `pc_misalign`  out  1: one-cycle pulse on a misaligned redirect target (see Configuration).

## Operation
- States: IDLE, FETCH, DROP, HOLD. Reset enters IDLE.
- Outputs:
  - `imem_req` = 1 in FETCH and DROP, 0 otherwise.
  - `imem_addr` is captured from `pc` on entry to FETCH and held until ack.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - Ack without redirect: capture `imem_rdata` into `id_instr`, capture `imem_addr+4` into `id_pc_plus4`, set `id_valid`, `pc <= pc+4`, go to HOLD.
  - Redirect without ack: `pc <= next_pc`, go to DROP.
  - Redirect with ack in the same cycle: discard the data, `pc <= next_pc`, re-enter FETCH at the new address.
- DROP:
  - Request stays high at the old address.
  - On ack: discard the data, go to FETCH.
  - A further redirect updates `pc` and stays in DROP.
- HOLD:
  - `id_ready` = 1: clear `id_valid`, go to FETCH.
  - Redirect: clear `id_valid`, `pc <= next_pc`, go to FETCH. Redirect has priority over `id_ready`.
- Sequential advance uses the internal `pc+4`; `next_pc` is sampled only when `redirect` = 1.
- Arithmetic: all PC values are 32-bit and wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset mid-fetch: everything returns to reset values immediately. An ack arriving while in IDLE is ignored.

## Timing
- Reset values:
  - `pc` = `imem_addr` = RESET_PC.
  - `imem_req` = 0, `id_valid` = 0, `id_instr` = 0, `id_pc_plus4` = 0, `pc_misalign` = 0.
- Latency:
  - `imem_req` rises 1 cycle after reset release.
  - `id_valid` rises the cycle after the ack edge.
  - Zero-wait memory (ack in the same cycle as req) gives 1 instruction per 2 cycles: FETCH, HOLD, FETCH, …
- Handshake:
  - `imem_addr` is stable while `imem_req` = 1.
  - `id_instr` and `id_pc_plus4` are stable while `id_valid` = 1 and `id_ready` = 0.
- Redirect takes effect at the next edge; the new `pc` is visible one cycle later.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A redirect with `next_pc[1:0]` != 0 loads the PC unchanged.
  - It also pulses `pc_misalign` high for one cycle.
  - Fetch proceeds at the unaligned address.
- `PC_ALIGN_CHECK_EN` undefined:
  - `next_pc[1:0]` is forced to 2'b00 on load.
  - `pc_misalign` is tied to 0.

## Test plan
- Reset release, zero-wait memory returning `addr` as data, `id_ready` = 1:
  - `imem_addr` sequence 0x3000, 0x3004, 0x3008.
  - `id_instr` = 0x3000 with `id_pc_plus4` = 0x3004, then 0x3004 with 0x3008.
- Ack delayed 3 cycles: `imem_req` stays high with `imem_addr` = 0x3000 for 4 cycles, and `id_valid` rises one cycle after the ack.
- `id_ready` = 0 for 5 cycles in HOLD: `id_valid`, `id_instr` and `pc` stay constant, and `imem_req` = 0 throughout.
- Redirect to 0x4000 in FETCH with ack 2 cycles later:
  - The old word is dropped and `id_valid` stays 0.
  - The next `imem_addr` is 0x4000.
- Redirect to 0x4002:
  - With the macro: `pc_misalign` pulses and `pc` = 0x4002.
  - Without the macro: `pc` = 0x4000 and `pc_misalign` = 0.
- `rst` asserted mid-DROP: `imem_req` = 0 and `pc` = 0x3000 immediately; a late ack does not set `id_valid`.
